lector_glifo: RTL and testbench
===============================

Name: lector_glifo

Overview:
- Downstream consumer of the BCD-digit address decoder.
- Takes the 11-bit glyph base address (0x420 + 0x30·digit, or 0 for an invalid digit) and walks the font ROM from that base.
- Streams each glyph byte to the video-buffer writer over a valid/ready handshake.
- One glyph is fetched per start pulse; the display controller sequences digits by toggling the decoder's nibble selector between glyphs.

Parameters:
- BYTES_GLIFO, 48, bytes per glyph; equals the decoder address stride 0x30.
- ANCHO_DIR, 11, ROM address width.
- ANCHO_DATO, 8, ROM data width and emitted byte width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- inicio  input  1  start pulse; sampled only in IDLE.
- direccion  input  ANCHO_DIR  glyph base address from the decoder; sampled with inicio.
- rom_dir  output  ANCHO_DIR  registered font-ROM address.
- rom_dato  input  ANCHO_DATO  font-ROM read data; synchronous ROM, 1-cycle latency.
- byte_out  output  ANCHO_DATO  emitted glyph byte.
- byte_valido  output  1  byte_out is valid.
- byte_listo  input  1  consumer accepts byte_out this cycle.
- indice  output  6  index 0..BYTES_GLIFO-1 of the byte currently on byte_out.
- ocupado  output  1  high in every state except IDLE.
- fin  output  1  one-cycle pulse after the last byte is accepted.
- invalido  output  1  sticky flag; set when a glyph starts with direccion==0.

Behaviour:
- Reset (reset==0 at a rising edge): state IDLE; rom_dir=0, byte_out=0, byte_valido=0, indice=0, ocupado=0, fin=0, invalido=0.
- Reset has priority over every event, including mid-glyph. The partial glyph is abandoned; no fin pulse.
- States: IDLE, DIR, CAPT, EMITE, FIN.
- IDLE:
  - On inicio=1: latch base=direccion, cnt=0, go to DIR.
  - If direccion==0: set invalido=1 and latch blank mode.
  - invalido clears only on reset or on the next inicio with direccion≠0.
- DIR: rom_dir=base+cnt, registered, valid during DIR; go to CAPT.
- CAPT:
  - rom_dato is valid this cycle; at the edge byte_out<=rom_dato (0x00 in blank mode), byte_valido<=1, indice<=cnt.
  - Go to EMITE.
- EMITE:
  - byte_out and indice hold stable while byte_valido=1 and byte_listo=0; no timeout.
  - On byte_listo=1 with cnt==BYTES_GLIFO-1: byte_valido<=0, go to FIN.
  - Otherwise on byte_listo=1: byte_valido<=0, cnt<=cnt+1, go to DIR.
- FIN: fin=1 for exactly one cycle, go to IDLE. ocupado drops on entry to IDLE.
- Address arithmetic: base+cnt computed in ANCHO_DIR bits and wraps modulo 2^11. No wrap occurs for legal bases; max 0x5D0+47=0x5FF.
- Blank mode: the FSM sequence and timing are identical to normal mode, including rom_dir stepping; every byte_out is 0x00.
- inicio outside IDLE is ignored, including in the FIN cycle. No queuing.
- byte_listo while byte_valido=0 is ignored.
- Minimum throughput: 3 cycles per byte.
- Latency inicio→first byte_valido: 3 cycles (IDLE edge, DIR, CAPT).
- Minimum glyph time with byte_listo held high: 3·48+1 = 145 cycles.

Optional Feature:
- Macro: LECTOR_GLIFO_ROM_LAT2_EN.
- Defined: the font ROM has 2-cycle read latency. An extra state ESPERA sits between DIR and CAPT. Per-byte minimum becomes 4 cycles; first-byte latency becomes 4 cycles; glyph time becomes 193 cycles.
- Undefined: 1-cycle ROM latency; the FSM and timing are exactly as above.
- Port list is identical in both builds.

Test Plan:
- Reset then idle, byte_listo held 1: all outputs 0. inicio with direccion=0x450 → rom_dir steps 0x450..0x47F; byte_out matches ROM contents; indice 0..47; fin pulses once at cycle 145; ocupado falls the next cycle.
- Backpressure: hold byte_listo=0 for 10 cycles at indice=5 → byte_out and indice stable, rom_dir unchanged; release → indice=6 follows 3 cycles later.
- Invalid digit: inicio with direccion=0 → invalido=1; 48 bytes of 0x00; fin pulses. Next inicio with direccion=0x5D0 → invalido=0, rom_dir ends at 0x5FF.
- inicio pulsed at indice=20 and again in the FIN cycle → both ignored; exactly 48 bytes and one fin.
- reset=0 asserted in EMITE at indice=30 → next cycle all outputs 0 and IDLE; no fin. Fresh inicio with 0x420 completes normally.
- With LECTOR_GLIFO_ROM_LAT2_EN defined, rerun the first scenario → first byte_valido 4 cycles after inicio; fin at cycle 193; data correct.

Source files
------------

// File: rtl/lector_glifo.sv
// lector_glifo: reads one glyph from the font ROM and streams it byte by byte.
// The glyph base address comes from the BCD digit decoder. A base of 0 marks an
// invalid digit: the glyph is then emitted blank, as all 0x00 bytes.
// Optional build macro: LECTOR_GLIFO_ROM_LAT2_EN adds an ESPERA state for a
// font ROM with a 2-cycle read latency. The port list is the same in both builds.
module lector_glifo #(
    parameter int BYTES_GLIFO = 48,
    parameter int ANCHO_DIR   = 11,
    parameter int ANCHO_DATO  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DIR-1:0]  rom_dir,
    input  logic [ANCHO_DATO-1:0] rom_dato,
    output logic [ANCHO_DATO-1:0] byte_out,
    output logic                  byte_valido,
    input  logic                  byte_listo,
    output logic [5:0]            indice,
    output logic                  ocupado,
    output logic                  fin,
    output logic                  invalido
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DIR    = 3'd1,
        ESPERA = 3'd2,
        CAPT   = 3'd3,
        EMITE  = 3'd4,
        FIN    = 3'd5
    } estado_t;

    estado_t                 estado_q;
    logic [ANCHO_DIR-1:0]    base_q;
    logic [5:0]              cnt_q;
    logic                    blanco_q;
    logic [ANCHO_DIR-1:0]    rom_dir_q;
    logic [ANCHO_DATO-1:0]   byte_out_q;
    logic                    valido_q;
    logic [5:0]              indice_q;
    logic                    ocupado_q;
    logic                    fin_q;
    logic                    invalido_q;

    logic [5:0]              cnt_sig_d;
    logic [ANCHO_DIR-1:0]    dir_sig_d;
    logic                    ultimo_s;
    logic                    dir_cero_s;

    // Next byte index and its ROM address. The address wraps modulo 2^ANCHO_DIR.
    assign cnt_sig_d  = cnt_q + 6'd1;
    assign dir_sig_d  = base_q + ANCHO_DIR'(cnt_sig_d);
    assign ultimo_s   = (cnt_q == 6'(BYTES_GLIFO - 1));
    assign dir_cero_s = (direccion == {ANCHO_DIR{1'b0}});

    // Glyph walker FSM. It drives every output from a register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q   <= IDLE;
            base_q     <= {ANCHO_DIR{1'b0}};
            cnt_q      <= 6'd0;
            blanco_q   <= 1'b0;
            rom_dir_q  <= {ANCHO_DIR{1'b0}};
            byte_out_q <= {ANCHO_DATO{1'b0}};
            valido_q   <= 1'b0;
            indice_q   <= 6'd0;
            ocupado_q  <= 1'b0;
            fin_q      <= 1'b0;
            invalido_q <= 1'b0;
        end else begin
            fin_q <= 1'b0;
            case (estado_q)
                IDLE: begin
                    if (inicio) begin
                        base_q     <= direccion;
                        cnt_q      <= 6'd0;
                        rom_dir_q  <= direccion;
                        blanco_q   <= dir_cero_s;
                        invalido_q <= dir_cero_s;
                        ocupado_q  <= 1'b1;
                        estado_q   <= DIR;
                    end else begin
                        estado_q <= IDLE;
                    end
                end
                DIR: begin
`ifdef LECTOR_GLIFO_ROM_LAT2_EN
                    estado_q <= ESPERA;
`else
                    estado_q <= CAPT;
`endif
                end
                ESPERA: begin
                    estado_q <= CAPT;
                end
                CAPT: begin
                    byte_out_q <= blanco_q ? {ANCHO_DATO{1'b0}} : rom_dato;
                    valido_q   <= 1'b1;
                    indice_q   <= cnt_q;
                    estado_q   <= EMITE;
                end
                EMITE: begin
                    if (byte_listo) begin
                        valido_q <= 1'b0;
                        if (ultimo_s) begin
                            fin_q    <= 1'b1;
                            estado_q <= FIN;
                        end else begin
                            cnt_q     <= cnt_sig_d;
                            rom_dir_q <= dir_sig_d;
                            estado_q  <= DIR;
                        end
                    end else begin
                        estado_q <= EMITE;
                    end
                end
                FIN: begin
                    ocupado_q <= 1'b0;
                    estado_q  <= IDLE;
                end
                default: begin
                    valido_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado_q  <= IDLE;
                end
            endcase
        end
    end

    assign rom_dir     = rom_dir_q;
    assign byte_out    = byte_out_q;
    assign byte_valido = valido_q;
    assign indice      = indice_q;
    assign ocupado     = ocupado_q;
    assign fin         = fin_q;
    assign invalido    = invalido_q;

endmodule

// File: tb/tb_lector_glifo.sv
// Self-checking bench for lector_glifo. It compares every output against a
// transaction-level model on every cycle and adds literal checks at the boundaries.
module tb_lector_glifo;

`ifdef LECTOR_GLIFO_ROM_LAT2_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif
    localparam int NB = 48;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        inicio = 1'b0;
    logic [10:0] direccion = 11'd0;
    logic [10:0] rom_dir;
    logic [7:0]  rom_dato = 8'd0;
    logic [7:0]  byte_out;
    logic        byte_valido;
    logic        byte_listo = 1'b1;
    logic [5:0]  indice;
    logic        ocupado;
    logic        fin;
    logic        invalido;

    int n_checks = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    lector_glifo dut (
        .clk(clk), .reset(reset), .inicio(inicio), .direccion(direccion),
        .rom_dir(rom_dir), .rom_dato(rom_dato), .byte_out(byte_out),
        .byte_valido(byte_valido), .byte_listo(byte_listo), .indice(indice),
        .ocupado(ocupado), .fin(fin), .invalido(invalido)
    );

    function automatic logic [7:0] rom_val(input logic [10:0] a);
        logic [10:0] p;
        p = a * 11'd37;
        return p[7:0] ^ 8'h5A;
    endfunction

    // Synchronous font ROM
`ifdef LECTOR_GLIFO_ROM_LAT2_EN
    logic [7:0] rom_p = 8'd0;
    always @(posedge clk) begin
        rom_p    <= rom_val(rom_dir);
        rom_dato <= rom_p;
    end
`else
    always @(posedge clk) rom_dato <= rom_val(rom_dir);
`endif

    // Model: expected outputs and the glyph in progress.
    logic [10:0] e_dir = 11'd0;
    logic [7:0]  e_byte = 8'd0;
    logic        e_valid = 1'b0;
    logic [5:0]  e_idx = 6'd0;
    logic        e_busy = 1'b0;
    logic        e_fin = 1'b0;
    logic        e_inv = 1'b0;
    logic [10:0] m_base = 11'd0;
    int          m_k = 0;
    logic        m_blank = 1'b0;
    int          m_wait = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advances the model by one clock edge, using the inputs sampled at that edge.
    task automatic model_step();
        if (!reset) begin
            e_dir = 11'd0; e_byte = 8'd0; e_valid = 1'b0; e_idx = 6'd0;
            e_busy = 1'b0; e_fin = 1'b0; e_inv = 1'b0; m_wait = 0;
        end else if (!e_busy) begin
            if (inicio) begin
                e_busy  = 1'b1;
                m_base  = direccion;
                m_k     = 0;
                m_blank = (direccion == 11'd0);
                e_inv   = (direccion == 11'd0);
                e_dir   = direccion;
                m_wait  = LAT - 1;
            end
        end else if (e_fin) begin
            e_fin  = 1'b0;
            e_busy = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                e_valid = 1'b1;
                e_byte  = m_blank ? 8'h00 : rom_val(11'(m_base + 11'(m_k)));
                e_idx   = 6'(m_k);
            end
        end else if (e_valid && byte_listo) begin
            e_valid = 1'b0;
            if (m_k == NB - 1) begin
                e_fin = 1'b1;
            end else begin
                m_k++;
                e_dir  = 11'(m_base + 11'(m_k));
                m_wait = LAT - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        @(negedge clk);
    endtask

    // Compare process: checks every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rom_dir", int'(rom_dir), int'(e_dir));
            chk("byte_valido", int'(byte_valido), int'(e_valid));
            chk("byte_out", int'(byte_out), int'(e_byte));
            chk("indice", int'(indice), int'(e_idx));
            chk("ocupado", int'(ocupado), int'(e_busy));
            chk("fin", int'(fin), int'(e_fin));
            chk("invalido", int'(invalido), int'(e_inv));
        end
    end

    // modo: 0 listo held high, 1 backpressure at indice 5, 2 random listo and inicio,
    //       3 inicio at indice 20 and in the FIN cycle, 4 reset at indice 30
    task automatic glifo(input logic [10:0] d, input int modo, output int nb, output int nf,
                         output int tf, output int tfin, output int b0);
        int n, bp, trel;
        bit done, relchk, p20;
        nb = 0; nf = 0; tf = -1; tfin = -1; b0 = -1;
        bp = 0; trel = -1; done = 1'b0; relchk = 1'b0; p20 = 1'b0;
        inicio = 1'b1; direccion = d; byte_listo = 1'b1;
        step();
        inicio = 1'b0;
        direccion = 11'($urandom);
        n = 1;
        while (!done && n < 2000) begin
            inicio = 1'b0;
            if (byte_valido && tf < 0) begin
                tf = n;
                b0 = int'(byte_out);
            end
            if (fin) begin
                nf++;
                tfin = n;
                done = 1'b1;
                if (modo == 3) inicio = 1'b1;
            end
            if (modo == 4 && byte_valido && indice == 6'd30) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                chk("rst_valido", int'(byte_valido), 0);
                chk("rst_ocupado", int'(ocupado), 0);
                chk("rst_indice", int'(indice), 0);
                chk("rst_byte", int'(byte_out), 0);
                chk("rst_rom_dir", int'(rom_dir), 0);
                for (int i = 0; i < 5; i++) begin
                    step();
                    chk("rst_sin_fin", int'(fin), 0);
                end
                return;
            end
            case (modo)
                1: begin
                    byte_listo = !(byte_valido && indice == 6'd5 && bp < 10);
                    if (!byte_listo) bp++;
                    else if (bp == 10 && trel < 0) trel = n;
                    if (trel >= 0 && !relchk && byte_valido && indice == 6'd6) begin
                        chk("bp_latencia", n - trel, LAT);
                        relchk = 1'b1;
                    end
                end
                2: begin
                    byte_listo = ($urandom_range(0, 3) != 0);
                    inicio     = ($urandom_range(0, 7) == 0);
                    direccion  = 11'($urandom);
                end
                3: begin
                    byte_listo = ($urandom_range(0, 3) != 0);
                    if (byte_valido && indice == 6'd20 && !p20) begin
                        inicio    = 1'b1;
                        direccion = 11'h123;
                        p20       = 1'b1;
                    end
                end
                default: byte_listo = 1'b1;
            endcase
            if (byte_valido && byte_listo) nb++;
            step();
            n++;
        end
        inicio = 1'b0;
        byte_listo = 1'b1;
        chk("glifo_termina", int'(done), 1);
        chk("ocupado_tras_fin", int'(ocupado), 0);
    endtask

    initial begin
        int nb, nf, tf, tfin, b0;
        reset = 1'b0;
        byte_listo = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b1;
        chk("ini_valido", int'(byte_valido), 0);
        chk("ini_ocupado", int'(ocupado), 0);
        chk("ini_rom_dir", int'(rom_dir), 0);
        chk("ini_invalido", int'(invalido), 0);
        step();
        step();

        // First scenario: normal glyph with byte_listo held high
        glifo(11'h450, 0, nb, nf, tf, tfin, b0);
        chk("s1_bytes", nb, NB);
        chk("s1_fins", nf, 1);
        chk("s1_latencia", tf, LAT);
        chk("s1_t_fin", tfin, LAT * NB + 1);
        chk("s1_byte0", b0, 8'hCA);
        chk("s1_rom_dir_fin", int'(rom_dir), 11'h47F);

        // Backpressure at indice 5
        glifo(11'h420, 1, nb, nf, tf, tfin, b0);
        chk("s2_bytes", nb, NB);
        chk("s2_fins", nf, 1);

        // Invalid digit, then a valid one at the top of the range
        glifo(11'h000, 2, nb, nf, tf, tfin, b0);
        chk("s3_bytes", nb, NB);
        chk("s3_fins", nf, 1);
        chk("s3_invalido", int'(invalido), 1);
        glifo(11'h5D0, 0, nb, nf, tf, tfin, b0);
        chk("s3b_invalido", int'(invalido), 0);
        chk("s3b_rom_dir_fin", int'(rom_dir), 11'h5FF);

        // inicio while busy and in the FIN cycle is ignored
        glifo(11'h4E0, 3, nb, nf, tf, tfin, b0);
        chk("s4_bytes", nb, NB);
        chk("s4_fins", nf, 1);
        step();
        chk("s4_quieto", int'(ocupado), 0);

        // Reset mid-glyph, then a fresh glyph
        glifo(11'h4B0, 4, nb, nf, tf, tfin, b0);
        chk("s5_sin_fin", nf, 0);
        glifo(11'h420, 0, nb, nf, tf, tfin, b0);
        chk("s5_bytes", nb, NB);
        chk("s5_fins", nf, 1);
        chk("s5_t_fin", tfin, LAT * NB + 1);

        // Random digits with random handshake
        for (int i = 0; i < 3; i++) begin
            glifo(11'(11'h420 + 11'h030 * 11'($urandom_range(0, 9))), 2, nb, nf, tf, tfin, b0);
            chk("rnd_bytes", nb, NB);
            chk("rnd_fins", nf, 1);
        end

        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
